sp_ram_port_ctrl: RTL and testbench
===================================

// Module: sp_ram_port_ctrl
// PURPOSE
//   Initiator side of the single-port RAM interface (en/addr/wdata/we/be -> rdata,
//   1-cycle read latency). Converts the core/bus req/gnt/rvalid data protocol into
//   RAM strobes, decodes the address window and flags out-of-range accesses.
//   Holds read data stable until the next response. Sits between the
//   interconnect slave port and sp_ram_wrap.
// PARAMETERS
//   RAM_SIZE    32768            RAM capacity in bytes (power of two)
//   DATA_WIDTH  32               data width; BE width = DATA_WIDTH/8
//   BUS_AW      32               bus address width
//   RAM_AW      $clog2(RAM_SIZE) RAM byte-address width
//   BASE_ADDR   32'h0010_0000    window base, aligned to RAM_SIZE
// PORTS
//   clk            in   1             clock
//   rstn_i         in   1             async active-low reset
//   data_req_i     in   1             request; held high until granted
//   data_gnt_o     out  1             grant
//   data_addr_i    in   BUS_AW        byte address
//   data_we_i      in   1             1 = write
//   data_be_i      in   DATA_WIDTH/8  byte enables
//   data_wdata_i   in   DATA_WIDTH    write data
//   data_rvalid_o  out  1             response valid (reads and writes)
//   data_rdata_o   out  DATA_WIDTH    read data, held until next rvalid
//   data_err_o     out  1             out-of-window access, valid with rvalid
//   ram_en_o       out  1             RAM enable
//   ram_addr_o     out  RAM_AW        RAM byte address = data_addr_i - BASE_ADDR
//   ram_wdata_o    out  DATA_WIDTH    RAM write data
//   ram_we_o       out  1             RAM write enable
//   ram_be_o       out  DATA_WIDTH/8  RAM byte enables
//   ram_rdata_i    in   DATA_WIDTH    RAM read data, valid 1 cycle after en
// BEHAVIOUR
//   - Reset: gnt=0, rvalid=0, err=0, rdata_o=0, ram_en/we=0, be=0, addr/wdata=0.
//   - FSM: CLEAR (only with macro), READY. Without macro, reset exits to READY.
//   - READY: gnt = req (combinational, same cycle). ram_* are combinational from
//     data_* when req & in-window; otherwise ram_en_o=0.
//   - In-window: BASE_ADDR <= addr < BASE_ADDR+RAM_SIZE. Offset is truncated to RAM_AW.
//   - Response: rvalid exactly 1 cycle after each granted request.
//     Back-to-back grants give back-to-back rvalids; no bubbles.
//   - Read in window: rdata_o <= ram_rdata_i in the rvalid cycle. The register holds
//     its value after the rvalid cycle.
//   - Write: rvalid, err=0, rdata_o unchanged.
//   - Out of window, read or write: no RAM access, rvalid+err=1, rdata_o=32'hBADACCE5.
//   - err is asserted only in rvalid cycles.
//   - be=0 write: RAM is still enabled (no bytes change); normal response.
//   - Async reset mid-transaction: pending response dropped, outputs return to reset
//     values, FSM restarts.
// CONFIGURATION
//   SP_RAM_CLEAR_ON_RESET_EN defined:
//     - After reset, FSM enters CLEAR and writes zeros, be all ones, to every word,
//       word address 0..RAM_SIZE/4-1, one per cycle, so RAM_SIZE/4 cycles.
//     - In CLEAR, gnt=0 and requests stall. READY is entered the cycle after the last
//       word is written.
//     - Reset during CLEAR restarts the sweep at word 0.
//   Undefined: no CLEAR state; READY in the first cycle after reset release.
//     RAM contents are untouched.
// STRUCTURE
//   sp_ram_ctrl_pkg:
//     - state enum ctrl_state_e {CLEAR, READY}
//     - ERR_RDATA = 32'hBADACCE5
//     - window-check function in_window(addr, base, size)
//   Sub-module sp_ram_clear_seq (word counter + done flag), instantiated only under
//   SP_RAM_CLEAR_ON_RESET_EN. RAM outputs are muxed between it and the request path.
// TESTING
//   1 Write 0x0010_0004 data 0xDEADBEEF be 4'hF, then read it -> gnt same cycle,
//     rvalid next cycle, rdata 0xDEADBEEF, err 0.
//   2 Write be 4'b0010 data 0x0000AA00 to the same word, then read -> rdata 0xDEADAAEF.
//   3 Read 0x0010_8000 (just past window) -> ram_en_o 0, rvalid 1, err 1,
//     rdata 0xBADACCE5.
//   4 Four back-to-back reads at 0x0010_0000..0C with req held high -> four
//     consecutive rvalids, data in order.
//   5 With SP_RAM_CLEAR_ON_RESET_EN, release reset with req high -> gnt 0 for 8192
//     cycles; then a read of 0x0010_7FFC returns 0.
//   6 Assert rstn_i for one cycle between a granted read and its rvalid -> no rvalid,
//     all outputs at reset values.

Source files
------------

// File: rtl/sp_ram_ctrl_pkg.sv
// Shared types, constants and helpers for the single-port RAM port controller.
package sp_ram_ctrl_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } ctrl_state_e;

  // Read data returned for any access outside the RAM window.
  localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

  // True when base <= addr < base + size; written so base + size may wrap.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    return (addr >= base) && ((addr - base) < size);
  endfunction

endpackage

// File: rtl/sp_ram_clear_seq.sv
// Word counter for the post-reset RAM zeroing sweep, with a last-word flag.
module sp_ram_clear_seq #(
  parameter int unsigned WORDS = 8192,
  parameter int unsigned WAW   = $clog2(WORDS)
) (
  input  logic           clk,
  input  logic           rstn_i,
  input  logic           en,
  output logic [WAW-1:0] word_addr,
  output logic           done
);

  // Advance one word per enabled cycle; reset restarts the sweep at word 0.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      word_addr <= '0;
    end else if (en) begin
      word_addr <= word_addr + WAW'(1);
    end
  end

  assign done = en && (word_addr == WAW'(WORDS - 1));

endmodule

// File: rtl/sp_ram_port_ctrl.sv
// Initiator side of the single-port RAM interface: turns req/gnt/rvalid bus
// accesses into RAM strobes, decodes the address window and flags misses.
// Optional build macro SP_RAM_CLEAR_ON_RESET_EN: zero every RAM word after reset
// before granting any request.
module sp_ram_port_ctrl
  import sp_ram_ctrl_pkg::*;
#(
  parameter int unsigned       RAM_SIZE   = 32768,
  parameter int unsigned       DATA_WIDTH = 32,
  parameter int unsigned       BUS_AW     = 32,
  parameter int unsigned       RAM_AW     = $clog2(RAM_SIZE),
  parameter logic [BUS_AW-1:0] BASE_ADDR  = BUS_AW'(32'h0010_0000)
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  input  logic [BUS_AW-1:0]       data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_err_o,
  output logic                    ram_en_o,
  output logic [RAM_AW-1:0]       ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int unsigned BEW = DATA_WIDTH / 8;

  ctrl_state_e           state_q, state_d;
  logic                  in_win;
  logic                  rsp_valid, rsp_we, rsp_err;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Combinational outputs are gated by rstn_i so they sit at reset values
  // while reset is asserted, even with a request held high.
  assign in_win     = in_window(32'(data_addr_i), 32'(BASE_ADDR), 32'(RAM_SIZE));
  assign data_gnt_o = rstn_i && (state_q == READY) && data_req_i;

`ifdef SP_RAM_CLEAR_ON_RESET_EN
  localparam int unsigned WORDS = RAM_SIZE / BEW;
  localparam int unsigned WAW   = $clog2(WORDS);

  logic           clear_en;
  logic [WAW-1:0] clear_word;
  logic           clear_done;

  sp_ram_clear_seq #(
    .WORDS (WORDS),
    .WAW   (WAW)
  ) u_clear_seq (
    .clk       (clk),
    .rstn_i    (rstn_i),
    .en        (clear_en),
    .word_addr (clear_word),
    .done      (clear_done)
  );
`endif

  // State register; with the clear feature the FSM starts in the sweep.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
`ifdef SP_RAM_CLEAR_ON_RESET_EN
      state_q <= CLEAR;
`else
      state_q <= READY;
`endif
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and RAM strobes, muxed between the clear sweep and the bus path.
  always_comb begin
    state_d     = state_q;
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
`ifdef SP_RAM_CLEAR_ON_RESET_EN
    clear_en    = 1'b0;
`endif
    case (state_q)
      CLEAR: begin
`ifdef SP_RAM_CLEAR_ON_RESET_EN
        if (rstn_i) begin
          clear_en   = 1'b1;
          ram_en_o   = 1'b1;
          ram_we_o   = 1'b1;
          ram_be_o   = '1;
          ram_addr_o = RAM_AW'(clear_word) << $clog2(BEW);
          if (clear_done) state_d = READY;
        end
`else
        state_d = READY;
`endif
      end
      READY: begin
        if (data_gnt_o && in_win) begin
          ram_en_o    = 1'b1;
          ram_we_o    = data_we_i;
          ram_be_o    = data_be_i;
          ram_addr_o  = RAM_AW'(data_addr_i - BASE_ADDR);
          ram_wdata_o = data_wdata_i;
        end
      end
      default: state_d = READY;
    endcase
  end

  // Read data shown in the response cycle; otherwise the held value.
  always_comb begin
    rdata_d = rdata_q;
    if (rsp_valid && rsp_err) begin
      rdata_d = DATA_WIDTH'(ERR_RDATA);
    end else if (rsp_valid && !rsp_we) begin
      rdata_d = ram_rdata_i;
    end
  end

  // One-cycle response pipeline and read-data hold register.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_err   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rsp_valid <= data_gnt_o;
      if (data_gnt_o) begin
        rsp_we  <= data_we_i;
        rsp_err <= !in_win;
      end
      rdata_q <= rdata_d;
    end
  end

  assign data_rvalid_o = rsp_valid;
  assign data_err_o    = rsp_valid && rsp_err;
  assign data_rdata_o  = rdata_d;

endmodule

// File: tb/tb_sp_ram_port_ctrl.sv
// Directed self-checking bench for sp_ram_port_ctrl with a behavioural RAM.
// Build with SP_RAM_CLEAR_ON_RESET_EN defined to cover the clear sweep.
module tb_sp_ram_port_ctrl;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        data_req_i;
  logic        data_gnt_o;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        ram_en_o;
  logic [14:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic        ram_we_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_rdata_i;

  logic [31:0] mem [0:8191] = '{default: 32'hFFFF_FFFF};

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [31:0] hold;
  logic [31:0] b2b [4];
  int unsigned stall;

  sp_ram_port_ctrl dut (
    .clk           (clk),
    .rstn_i        (rstn_i),
    .data_req_i    (data_req_i),
    .data_gnt_o    (data_gnt_o),
    .data_addr_i   (data_addr_i),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_wdata_i  (data_wdata_i),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .data_err_o    (data_err_o),
    .ram_en_o      (ram_en_o),
    .ram_addr_o    (ram_addr_o),
    .ram_wdata_o   (ram_wdata_o),
    .ram_we_o      (ram_we_o),
    .ram_be_o      (ram_be_o),
    .ram_rdata_i   (ram_rdata_i)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM, one-cycle read latency, byte-enabled writes.
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_be_o[b]) mem[ram_addr_o[14:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
        end
      end else begin
        ram_rdata_i <= mem[ram_addr_o[14:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_addr_i  = '0;
    data_be_i    = '0;
    data_wdata_i = '0;
  endtask

  // One isolated access; exp_rdata applies to reads and window misses,
  // in-window writes must leave the held read data unchanged.
  task automatic single(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        input logic exp_en, input logic exp_err, input logic [31:0] exp_rdata);
    logic [31:0] exp_d;
    exp_d = (we && !exp_err) ? hold : exp_rdata;
    cyc();
    data_req_i = 1'b1; data_we_i = we; data_addr_i = addr; data_be_i = be; data_wdata_i = wdata;
    @(negedge clk);
    chk({tag, ".gnt"}, 32'(data_gnt_o), 32'd1);
    chk({tag, ".ram_en"}, 32'(ram_en_o), 32'(exp_en));
    if (exp_en) chk({tag, ".ram_addr"}, 32'(ram_addr_o), addr - 32'h0010_0000);
    chk({tag, ".early_rvalid"}, 32'(data_rvalid_o), 32'd0);
    cyc();
    idle();
    @(negedge clk);
    chk({tag, ".rvalid"}, 32'(data_rvalid_o), 32'd1);
    chk({tag, ".err"}, 32'(data_err_o), 32'(exp_err));
    chk({tag, ".rdata"}, data_rdata_o, exp_d);
    cyc();
    @(negedge clk);
    chk({tag, ".rvalid_drop"}, 32'(data_rvalid_o), 32'd0);
    chk({tag, ".err_drop"}, 32'(data_err_o), 32'd0);
    chk({tag, ".rdata_hold"}, data_rdata_o, exp_d);
    hold = exp_d;
  endtask

  initial begin
    // Reset with a write request held high: everything must stay quiet.
    rstn_i = 1'b0;
    data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h0010_0004;
    data_be_i = 4'hF; data_wdata_i = 32'hFFFF_FFFF;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst.gnt", 32'(data_gnt_o), 32'd0);
    chk("rst.rvalid", 32'(data_rvalid_o), 32'd0);
    chk("rst.err", 32'(data_err_o), 32'd0);
    chk("rst.rdata", data_rdata_o, 32'd0);
    chk("rst.ram_en", 32'(ram_en_o), 32'd0);
    chk("rst.ram_we", 32'(ram_we_o), 32'd0);
    chk("rst.ram_be", 32'(ram_be_o), 32'd0);
    chk("rst.ram_addr", 32'(ram_addr_o), 32'd0);
    chk("rst.ram_wdata", ram_wdata_o, 32'd0);

    // Release reset with a read of word 0 pending.
    cyc();
    data_we_i = 1'b0; data_addr_i = 32'h0010_0000; data_be_i = 4'hF; data_wdata_i = '0;
    rstn_i = 1'b1;
    @(negedge clk);
`ifdef SP_RAM_CLEAR_ON_RESET_EN
    chk("clear.ram_en", 32'(ram_en_o), 32'd1);
    chk("clear.ram_we", 32'(ram_we_o), 32'd1);
    chk("clear.ram_be", 32'(ram_be_o), 32'hF);
    chk("clear.ram_addr", 32'(ram_addr_o), 32'd0);
    chk("clear.ram_wdata", ram_wdata_o, 32'd0);
`else
    chk("ready.ram_en", 32'(ram_en_o), 32'd1);
    chk("ready.ram_we", 32'(ram_we_o), 32'd0);
`endif
    stall = 0;
    while (data_gnt_o === 1'b0 && stall < 10000) begin
      stall++;
      @(negedge clk);
    end
`ifdef SP_RAM_CLEAR_ON_RESET_EN
    chk("startup.stall_cycles", stall, 32'd8192);
`else
    chk("startup.stall_cycles", stall, 32'd0);
`endif
    cyc();
    idle();
    @(negedge clk);
    chk("startup.rvalid", 32'(data_rvalid_o), 32'd1);
`ifdef SP_RAM_CLEAR_ON_RESET_EN
    chk("startup.rdata", data_rdata_o, 32'h0000_0000);
    hold = 32'h0000_0000;
`else
    chk("startup.rdata", data_rdata_o, 32'hFFFF_FFFF);
    hold = 32'hFFFF_FFFF;
`endif

    // Full write then read back; partial byte write merges into the word.
    single("wr_full", 1'b1, 32'h0010_0004, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    single("rd_full", 1'b0, 32'h0010_0004, 4'hF, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    single("wr_be", 1'b1, 32'h0010_0004, 4'b0010, 32'h0000_AA00, 1'b1, 1'b0, 32'h0);
    single("rd_be", 1'b0, 32'h0010_0004, 4'hF, 32'h0, 1'b1, 1'b0, 32'hDEAD_AAEF);

    // Window edges: just past the top, just below the base, last in-window word.
    single("rd_past", 1'b0, 32'h0010_8000, 4'hF, 32'h0, 1'b0, 1'b1, 32'hBADA_CCE5);
    single("wr_below", 1'b1, 32'h000F_FFFC, 4'hF, 32'h1234_5678, 1'b0, 1'b1, 32'hBADA_CCE5);
`ifdef SP_RAM_CLEAR_ON_RESET_EN
    single("rd_top", 1'b0, 32'h0010_7FFC, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0000_0000);
`else
    single("rd_top", 1'b0, 32'h0010_7FFC, 4'hF, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFF);
`endif

    // Fill words 0, 2, 3; a be=0 write must leave word 3 intact.
    single("wr_w0", 1'b1, 32'h0010_0000, 4'hF, 32'h1111_1111, 1'b1, 1'b0, 32'h0);
    single("wr_w2", 1'b1, 32'h0010_0008, 4'hF, 32'h2222_2222, 1'b1, 1'b0, 32'h0);
    single("wr_w3", 1'b1, 32'h0010_000C, 4'hF, 32'h3333_3333, 1'b1, 1'b0, 32'h0);
    single("wr_be0", 1'b1, 32'h0010_000C, 4'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);

    // Four back-to-back reads with req held high.
    b2b = '{32'h1111_1111, 32'hDEAD_AAEF, 32'h2222_2222, 32'h3333_3333};
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (k < 4) begin
        data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF;
        data_addr_i = 32'h0010_0000 + 32'(4 * k);
      end else begin
        idle();
      end
      @(negedge clk);
      if (k < 4) chk($sformatf("b2b%0d.gnt", k), 32'(data_gnt_o), 32'd1);
      if (k > 0) begin
        chk($sformatf("b2b%0d.rvalid", k - 1), 32'(data_rvalid_o), 32'd1);
        chk($sformatf("b2b%0d.rdata", k - 1), data_rdata_o, b2b[k-1]);
      end else begin
        chk("b2b.pre_rvalid", 32'(data_rvalid_o), 32'd0);
      end
    end
    cyc();
    @(negedge clk);
    chk("b2b.rvalid_drop", 32'(data_rvalid_o), 32'd0);
    chk("b2b.rdata_hold", data_rdata_o, 32'h3333_3333);

    // Reset between a granted read and its response drops the response.
    cyc();
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0010_0004; data_be_i = 4'hF;
    @(negedge clk);
    chk("midrst.gnt_before", 32'(data_gnt_o), 32'd1);
    #1;
    rstn_i = 1'b0;
    #1;
    chk("midrst.gnt", 32'(data_gnt_o), 32'd0);
    chk("midrst.ram_en", 32'(ram_en_o), 32'd0);
    chk("midrst.rvalid", 32'(data_rvalid_o), 32'd0);
    chk("midrst.rdata", data_rdata_o, 32'd0);
    cyc();
    idle();
    rstn_i = 1'b1;
    @(negedge clk);
    chk("midrst.rvalid_after", 32'(data_rvalid_o), 32'd0);
    chk("midrst.err_after", 32'(data_err_o), 32'd0);
    chk("midrst.rdata_after", data_rdata_o, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
